// File: rtl/k051316_pkg.sv
// Shared types for the 051316 loader.
//   state_t  : loader FSM states.
//   cmd_t    : one queued bus write (target select, address, data, blank-only flag).
//   bus_addr : maps a command to the address driven on the 051316 bus.
package k051316_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAITBLK = 3'd1,
        ST_SETUP   = 3'd2,
        ST_STROBE  = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    typedef struct packed {
        logic        sel;        // 0 = register (IOCS), 1 = VRAM (VRCS)
        logic [10:0] addr;
        logic [7:0]  data;
        logic        blankonly;  // hold the write until vertical blank
    } cmd_t;

    // The register file only decodes four address bits.
    localparam logic [10:0] REG_ADDR_MASK = 11'h00F;

    function automatic logic [10:0] bus_addr(input cmd_t c);
        return c.sel ? c.addr : (c.addr & REG_ADDR_MASK);
    endfunction

endpackage

// File: rtl/k051316_loader_if.sv
// Command handshake and 051316 bus signals of the loader.
//   master : command source / bus observer (drives CMD_*, VSCN).
//   slave  : the loader (drives CMD_READY, chip selects, RW, A, DOUT, DOE, BUSY, DONE).
interface k051316_loader_if;

    logic        CMD_VALID;
    logic        CMD_READY;
    logic        CMD_SEL;
    logic [10:0] CMD_ADDR;
    logic [7:0]  CMD_DATA;
    logic        CMD_BLANKONLY;
    logic        VSCN;
    logic        IOCS;
    logic        VRCS;
    logic        RW;
    logic [10:0] A;
    logic [7:0]  DOUT;
    logic        DOE;
    logic        BUSY;
    logic        DONE;

    modport master (
        output CMD_VALID, CMD_SEL, CMD_ADDR, CMD_DATA, CMD_BLANKONLY, VSCN,
        input  CMD_READY, IOCS, VRCS, RW, A, DOUT, DOE, BUSY, DONE
    );

    modport slave (
        input  CMD_VALID, CMD_SEL, CMD_ADDR, CMD_DATA, CMD_BLANKONLY, VSCN,
        output CMD_READY, IOCS, VRCS, RW, A, DOUT, DOE, BUSY, DONE
    );

endinterface

// File: rtl/k051316_cmd_fifo.sv
// Show-ahead command FIFO for the loader.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO).
//   push     : write wdata when not full.
//   pop      : drop the head entry when not empty.
//   rdata    : current head entry (valid when !empty).
//   full, empty : occupancy flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module k051316_cmd_fifo
    import k051316_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t wdata,
    input  logic pop,
    output cmd_t rdata,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/k051316_loader.sv
// Queued write sequencer for the Konami 051316 register/VRAM bus.
//   M12  : system clock, rising edge.
//   RST  : synchronous active-high reset; aborts any write in progress.
//   bus  : command handshake (CMD_VALID/CMD_READY, CMD_SEL, CMD_ADDR,
//          CMD_DATA, CMD_BLANKONLY), VSCN input, and the registered bus
//          outputs IOCS, VRCS, RW, A, DOUT, DOE plus BUSY and DONE.
// Each write runs SETUP_CYC setup, STROBE_CYC strobe and HOLD_CYC hold
// cycles; blank-only writes wait in WAITBLK until VSCN is sampled low.
module k051316_loader
    import k051316_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            M12,
    input  logic            RST,
    k051316_loader_if.slave bus
);

    localparam int unsigned CNT_MAX =
        (SETUP_CYC > STROBE_CYC) ?
            ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
            ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    cmd_t             cur;
    cmd_t             in_cmd;
    cmd_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    logic             iocs_q;
    logic             vrcs_q;
    logic             rw_q;
    logic [10:0]      a_q;
    logic [7:0]       dout_q;
    logic             doe_q;
    logic             done_q;

    always_comb begin
        in_cmd           = '0;
        in_cmd.sel       = bus.CMD_SEL;
        in_cmd.addr      = bus.CMD_ADDR;
        in_cmd.data      = bus.CMD_DATA;
        in_cmd.blankonly = bus.CMD_BLANKONLY;
    end

    // The head is consumed the moment the FSM leaves IDLE with it.
    assign pop = (state == ST_IDLE) && !fifo_empty;

    k051316_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (M12),
        .rst   (RST),
        .push  (bus.CMD_VALID),
        .wdata (in_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.CMD_READY = !fifo_full;
    assign bus.BUSY      = !fifo_empty || (state != ST_IDLE);
    assign bus.IOCS      = iocs_q;
    assign bus.VRCS      = vrcs_q;
    assign bus.RW        = rw_q;
    assign bus.A         = a_q;
    assign bus.DOUT      = dout_q;
    assign bus.DOE       = doe_q;
    assign bus.DONE      = done_q;

    // Outputs are registered alongside the state: each transition also sets
    // the bus levels that belong to the state being entered.
    always_ff @(posedge M12) begin
        if (RST) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            cur    <= '0;
            iocs_q <= 1'b1;
            vrcs_q <= 1'b1;
            rw_q   <= 1'b1;
            a_q    <= '0;
            dout_q <= '0;
            doe_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur <= head;
                        cnt <= '0;
                        if (head.blankonly && bus.VSCN) begin
                            state <= ST_WAITBLK;
                        end else begin
                            state  <= ST_SETUP;
                            a_q    <= bus_addr(head);
                            dout_q <= head.data;
                            doe_q  <= 1'b1;
                        end
                    end
                end

                ST_WAITBLK: begin
                    if (!bus.VSCN) begin
                        state  <= ST_SETUP;
                        a_q    <= bus_addr(cur);
                        dout_q <= cur.data;
                        doe_q  <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt    <= '0;
                        state  <= ST_STROBE;
                        iocs_q <= cur.sel;
                        vrcs_q <= !cur.sel;
                        rw_q   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_STROBE: begin
                    if (cnt == STROBE_LAST) begin
                        cnt    <= '0;
                        state  <= ST_HOLD;
                        iocs_q <= 1'b1;
                        vrcs_q <= 1'b1;
                        rw_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt    <= '0;
                        state  <= ST_IDLE;
                        a_q    <= '0;
                        dout_q <= '0;
                        doe_q  <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    iocs_q <= 1'b1;
                    vrcs_q <= 1'b1;
                    rw_q   <= 1'b1;
                    a_q    <= '0;
                    dout_q <= '0;
                    doe_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_k051316_loader.sv
// Scoreboard bench for k051316_loader: accepted commands queue their expected
// bus write; a monitor pops and checks each strobe, plus timing and bus rules.
module tb_k051316_loader;

    localparam int S = 2;
    localparam int T = 2;
    localparam int H = 2;
    localparam int D = 4;

    typedef struct {
        bit        sel;
        bit [10:0] addr;
        bit [7:0]  data;
    } exp_t;

    logic M12;
    logic RST;
    k051316_loader_if bus ();

    k051316_loader #(
        .SETUP_CYC  (S),
        .STROBE_CYC (T),
        .HOLD_CYC   (H),
        .FIFO_DEPTH (D)
    ) dut (
        .M12 (M12),
        .RST (RST),
        .bus (bus.slave)
    );

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   strobe_count = 0;
    int   done_count = 0;
    int   last_strobe_cyc = -1;
    int   last_done_cyc = -1;
    int   doe_rise_cyc = 0;
    int   low_run = 0;
    bit   pending = 0;
    bit   prev_doe = 0;
    bit   prev_done = 0;
    bit   cs_low;
    logic [10:0] last_strobe_a = '0;
    logic [18:0] held = '0;
    exp_t mon_e;
    exp_t exp_q[$];

    bit   vscn_set = 0;
    bit   vscn_rnd = 0;
    bit   vscn_rand_en = 0;

    assign bus.VSCN = vscn_rand_en ? vscn_rnd : vscn_set;

    initial M12 = 1'b0;
    always #5 M12 = ~M12;

    always @(posedge M12) cyc = cyc + 1;

    always @(negedge M12) vscn_rnd = ($urandom_range(0, 3) != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples 2 time units after every rising edge.
    always @(posedge M12) begin
        #2;
        if (RST) begin
            low_run   = 0;
            pending   = 0;
            prev_doe  = 0;
            prev_done = 0;
            exp_q.delete();
        end else begin
            cs_low = !bus.IOCS || !bus.VRCS;
            check("cs_exclusive", 32'(!bus.IOCS && !bus.VRCS), 32'd0);
            if (!bus.DOE) check("idle_bus_zero", 32'({bus.A, bus.DOUT}), 32'd0);
            if (bus.DOE && !prev_doe) doe_rise_cyc = cyc;
            if (cs_low && low_run == 0) begin
                strobe_count++;
                last_strobe_cyc = cyc;
                last_strobe_a   = bus.A;
                held            = {bus.A, bus.DOUT};
                pending         = 1;
                check("setup_len", cyc - doe_rise_cyc, S);
                check("strobe_rw", 32'(bus.RW), 32'd0);
                check("strobe_doe", 32'(bus.DOE), 32'd1);
                check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("strobe_cs", 32'({bus.IOCS, bus.VRCS}), mon_e.sel ? 32'd2 : 32'd1);
                    check("strobe_addr", 32'(bus.A), 32'(mon_e.addr));
                    check("strobe_data", 32'(bus.DOUT), 32'(mon_e.data));
                end
            end
            if (cs_low) begin
                low_run++;
            end else begin
                if (low_run != 0) check("strobe_len", low_run, T);
                low_run = 0;
                if (pending && !bus.DONE) begin
                    check("hold_stable", 32'({bus.A, bus.DOUT}), 32'(held));
                    check("hold_doe", 32'(bus.DOE), 32'd1);
                end
            end
            if (bus.DONE) begin
                done_count++;
                last_done_cyc = cyc;
                check("done_expected", 32'(pending), 32'd1);
                check("done_pulse", 32'(prev_done), 32'd0);
                if (pending) check("done_timing", cyc - last_strobe_cyc, T + H);
                pending = 0;
            end
            prev_doe  = bus.DOE;
            prev_done = bus.DONE;
        end
    end

    // Called at a falling edge; returns at a falling edge.
    task automatic push_cmd(input bit sel, input bit [10:0] addr, input bit [7:0] data,
                            input bit blank, input int max_wait, output bit ok, output int acc);
        exp_t e;
        ok  = 0;
        acc = -1;
        bus.CMD_SEL       = sel;
        bus.CMD_ADDR      = addr;
        bus.CMD_DATA      = data;
        bus.CMD_BLANKONLY = blank;
        bus.CMD_VALID     = 1'b1;
        for (int i = 0; i < max_wait && !ok; i++) begin
            ok = bus.CMD_READY;
            @(posedge M12);
            if (ok) begin
                e.sel  = sel;
                e.addr = sel ? addr : 11'(addr % 11'd16);
                e.data = data;
                exp_q.push_back(e);
            end
            @(negedge M12);
            if (ok) acc = cyc;
        end
        bus.CMD_VALID = 1'b0;
    endtask

    task automatic push_req(input bit sel, input bit [10:0] addr, input bit [7:0] data,
                            input bit blank, output int acc);
        bit ok;
        push_cmd(sel, addr, data, blank, 400, ok, acc);
        check("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n = 0;
        while (bus.BUSY && n < max_cyc) begin
            @(negedge M12);
            n++;
        end
        // let a trailing DONE be seen by the monitor
        repeat (2) @(negedge M12);
        check(name, 32'(bus.BUSY), 32'd0);
    endtask

    initial begin
        int  e0;
        int  e1;
        int  ef;
        int  acc;
        int  sc;
        int  dc;
        bit  ok;

        RST               = 1'b1;
        bus.CMD_VALID     = 1'b0;
        bus.CMD_SEL       = 1'b0;
        bus.CMD_ADDR      = '0;
        bus.CMD_DATA      = '0;
        bus.CMD_BLANKONLY = 1'b0;
        repeat (3) @(negedge M12);

        check("rst_iocs", 32'(bus.IOCS), 32'd1);
        check("rst_vrcs", 32'(bus.VRCS), 32'd1);
        check("rst_rw", 32'(bus.RW), 32'd1);
        check("rst_doe", 32'(bus.DOE), 32'd0);
        check("rst_a", 32'(bus.A), 32'd0);
        check("rst_dout", 32'(bus.DOUT), 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_ready", 32'(bus.CMD_READY), 32'd1);
        RST = 1'b0;
        @(negedge M12);

        // Register write, latency from acceptance
        push_req(1'b0, 11'd14, 8'h05, 1'b0, e0);
        wait_idle("reg_drain", 100);
        check("reg_strobe_edge", last_strobe_cyc, e0 + 1 + S);
        check("reg_done_edge", last_done_cyc, e0 + 1 + S + T + H);
        check("reg_addr", 32'(last_strobe_a), 32'h00E);

        // Register address keeps only the low nibble
        push_req(1'b0, 11'h7F5, 8'h3C, 1'b0, acc);
        wait_idle("mask_drain", 100);
        check("reg_addr_mask", 32'(last_strobe_a), 32'h005);

        // Back-to-back: one IDLE cycle between HOLD exit and next SETUP
        push_req(1'b1, 11'h2A7, 8'hC3, 1'b0, e0);
        push_req(1'b0, 11'h019, 8'h7E, 1'b0, e1);
        check("b2b_accept", e1, e0 + 1);
        wait_idle("b2b_drain", 100);
        check("b2b_strobe_edge", last_strobe_cyc, e0 + 1 + S + T + H + 1 + S);
        check("b2b_done_edge", last_done_cyc, e0 + 2 * (1 + S + T + H));

        // Blank-only VRAM write stalls while VSCN is high
        vscn_set = 1'b1;
        push_req(1'b1, 11'h400, 8'h80, 1'b1, acc);
        sc = strobe_count;
        repeat (50) @(negedge M12);
        check("blank_no_strobe", strobe_count, sc);
        check("blank_doe_low", 32'(bus.DOE), 32'd0);
        check("blank_busy", 32'(bus.BUSY), 32'd1);
        vscn_set = 1'b0;
        @(posedge M12);
        @(negedge M12);
        ef = cyc;
        check("blank_setup_doe", 32'(bus.DOE), 32'd1);
        check("blank_setup_addr", 32'(bus.A), 32'h400);
        check("blank_setup_data", 32'(bus.DOUT), 32'h80);
        wait_idle("blank_drain", 100);
        check("blank_strobe_edge", last_strobe_cyc, ef + S);

        // FIFO full while the engine is stalled in WAITBLK
        vscn_set = 1'b1;
        push_req(1'b0, 11'h123, 8'h11, 1'b1, acc);
        repeat (2) @(negedge M12);
        for (int i = 0; i < D; i++) begin
            push_req(1'b0, 11'(i), 8'(8'hA0 + i), 1'b1, acc);
        end
        check("full_ready_low", 32'(bus.CMD_READY), 32'd0);
        push_cmd(1'b1, 11'h555, 8'h55, 1'b0, 8, ok, acc);
        check("full_blocks_5th", 32'(ok), 32'd0);
        vscn_set = 1'b0;
        push_cmd(1'b1, 11'h555, 8'h55, 1'b0, 50, ok, acc);
        check("fifth_accepted", 32'(ok), 32'd1);
        check("fifth_after_pop", acc, last_done_cyc + 2);
        wait_idle("full_drain", 300);

        // Reset during a strobe with three commands queued
        push_req(1'b0, 11'd16, 8'h01, 1'b0, e0);
        for (int i = 1; i < 4; i++) push_req(1'b0, 11'(16 + i), 8'(i + 1), 1'b0, acc);
        while (cyc < e0 + 1 + S) @(negedge M12);
        check("rst_pre_strobe", 32'(bus.IOCS), 32'd0);
        RST = 1'b1;
        @(posedge M12);
        @(negedge M12);
        check("abort_iocs", 32'(bus.IOCS), 32'd1);
        check("abort_vrcs", 32'(bus.VRCS), 32'd1);
        check("abort_rw", 32'(bus.RW), 32'd1);
        check("abort_doe", 32'(bus.DOE), 32'd0);
        check("abort_busy", 32'(bus.BUSY), 32'd0);
        check("abort_done", 32'(bus.DONE), 32'd0);
        check("abort_ready", 32'(bus.CMD_READY), 32'd1);
        RST = 1'b0;
        sc = strobe_count;
        dc = done_count;
        repeat (30) @(negedge M12);
        check("abort_no_strobe", strobe_count, sc);
        check("abort_no_done", done_count, dc);
        check("abort_idle", 32'(bus.BUSY), 32'd0);

        // Randomized stream with VSCN toggling
        vscn_rand_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge M12);
            push_req(1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)),
                     8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), acc);
        end
        vscn_rand_en = 1'b0;
        vscn_set     = 1'b0;
        wait_idle("rand_drain", 1000);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("no_pending_done", 32'(pending), 32'd0);
        check("done_per_strobe", strobe_count - done_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
